h_u_dsrca: RTL and testbench

- Parametrised digit-serial unsigned ripple-carry adder/subtractor for area-constrained datapaths.
- Each cycle, one DIGIT-wide slice is summed through a chain of ha/fa cells, so only DIGIT cells are instantiated instead of WIDTH.
- The carry is held in a register between slices.
- Operands arrive and results leave through valid/ready handshakes; the block sits between operand registers and result consumers in the arithmetic library.

---
 rtl/h_u_dsrca.sv | 204 ++++++++++++++++++++
 tb/tb_h_u_dsrca.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_u_dsrca.sv
// h_u_dsrca: digit-serial unsigned ripple-carry adder/subtractor.
// Each RUN cycle, one DIGIT-wide slice of the operands goes through a chain of
// DIGIT full-adder cells. The slice carry is kept in a register between slices.
// Operands arrive and results leave through valid/ready handshakes.
// Optional build macro: H_U_DSRCA_SIGNED_OVF_EN adds the signed-overflow output ovf.

module h_u_dsrca_ha (
  input  logic i_x,
  input  logic i_y,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_x ^ i_y;
  assign o_c = i_x & i_y;
endmodule

module h_u_dsrca_fa (
  input  logic i_x,
  input  logic i_y,
  input  logic i_ci,
  output logic o_s,
  output logic o_co
);
  logic w_s0;
  logic w_c0;
  logic w_c1;

  h_u_dsrca_ha u_ha0 (.i_x(i_x),  .i_y(i_y),  .o_s(w_s0), .o_c(w_c0));
  h_u_dsrca_ha u_ha1 (.i_x(w_s0), .i_y(i_ci), .o_s(o_s),  .o_c(w_c1));

  assign o_co = w_c0 | w_c1;
endmodule

module h_u_dsrca #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   out,
  output logic             busy
`ifdef H_U_DSRCA_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  if ((DIGIT == 0) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("h_u_dsrca: WIDTH must be a non-zero integer multiple of DIGIT");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] w_res_nxt;
  logic             r_carry;
  logic             r_sub;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH:0]   r_out;
  logic             r_out_valid;

  logic [DIGIT-1:0] w_a_sl;
  logic [DIGIT-1:0] w_b_sl;
  logic [DIGIT-1:0] w_sum;
  logic [DIGIT:0]   w_c;
  logic             w_last;
  logic             w_accept;
  logic             w_msb;

  assign in_ready  = (r_state == S_IDLE) & ~rst;
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out       = r_out;

  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_cnt == CW'(NDIG - 1));

  // Select the operand slice addressed by the digit counter
  always_comb begin
    w_a_sl = '0;
    w_b_sl = '0;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_cnt == CW'(i)) begin
        w_a_sl = r_a[i*DIGIT +: DIGIT];
        w_b_sl = r_b[i*DIGIT +: DIGIT];
      end
    end
  end

  // Ripple chain of DIGIT cells, fed by the registered inter-slice carry
  assign w_c[0] = r_carry;
  for (genvar g = 0; g < DIGIT; g++) begin : g_cell
    h_u_dsrca_fa u_fa (
      .i_x (w_a_sl[g]),
      .i_y (w_b_sl[g]),
      .i_ci(w_c[g]),
      .o_s (w_sum[g]),
      .o_co(w_c[g+1])
    );
  end

  // Merge the current slice sum into the partial result
  always_comb begin
    w_res_nxt = r_res;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (r_cnt == CW'(i)) begin
        w_res_nxt[i*DIGIT +: DIGIT] = w_sum;
      end
    end
  end

  // Subtraction reports borrow, which is the inverted final carry
  assign w_msb = r_sub ? ~w_c[DIGIT] : w_c[DIGIT];

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept)  w_state_nxt = S_RUN;
      S_RUN:  if (w_last)    w_state_nxt = S_DONE;
      S_DONE: if (out_ready) w_state_nxt = S_IDLE;
      default:               w_state_nxt = S_IDLE;
    endcase
  end

  // Operand capture, per-slice accumulation and result publication
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_sub       <= 1'b0;
      r_cnt       <= '0;
      r_out       <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_a     <= a;
        r_b     <= b ^ {WIDTH{sub}};
        r_carry <= sub;
        r_sub   <= sub;
        r_cnt   <= '0;
      end
      if (r_state == S_RUN) begin
        r_res   <= w_res_nxt;
        r_carry <= w_c[DIGIT];
        if (w_last) begin
          r_out       <= {w_msb, w_res_nxt};
          r_out_valid <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
      if ((r_state == S_DONE) && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

`ifdef H_U_DSRCA_SIGNED_OVF_EN
  logic r_ovf;

  assign ovf = r_ovf;

  // Signed overflow: carry into the top bit differs from carry out of it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if ((r_state == S_RUN) && w_last) begin
      r_ovf <= w_c[DIGIT-1] ^ w_c[DIGIT];
    end
  end
`endif

endmodule

// File: tb/tb_h_u_dsrca.sv
// Self-checking bench for h_u_dsrca: a 32/8 instance for directed scenarios and
// three 16-bit instances (DIGIT 16, 4, 1) for random add/sub traffic.

module tb_h_u_dsrca;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 8;
  localparam int unsigned ND = W / D;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          sub;
  logic          out_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          in_ready;
  logic          out_valid;
  logic          busy;
  logic [W:0]    out;

  logic          in_valid16;
  logic          sub16;
  logic          out_ready16;
  logic [15:0]   a16;
  logic [15:0]   b16;
  logic          ir16 [3];
  logic          ov16 [3];
  logic          bz16 [3];
  logic [16:0]   o16  [3];

`ifdef H_U_DSRCA_SIGNED_OVF_EN
  logic          ovf;
  logic          ovf16 [3];
  logic          sbo [$];
`endif

  int            n_tests = 0;
  int            n_fail  = 0;
  logic [W:0]    sb [$];
  logic [16:0]   sb16_0 [$];
  logic [16:0]   sb16_1 [$];
  logic [16:0]   sb16_2 [$];

  always #5 clk = ~clk;

  h_u_dsrca #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .busy(busy)
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    , .ovf(ovf)
`endif
  );

  h_u_dsrca #(.WIDTH(16), .DIGIT(16)) dut16_0 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ir16[0]),
    .a(a16), .b(b16), .sub(sub16), .out_valid(ov16[0]), .out_ready(out_ready16),
    .out(o16[0]), .busy(bz16[0])
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    , .ovf(ovf16[0])
`endif
  );

  h_u_dsrca #(.WIDTH(16), .DIGIT(4)) dut16_1 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ir16[1]),
    .a(a16), .b(b16), .sub(sub16), .out_valid(ov16[1]), .out_ready(out_ready16),
    .out(o16[1]), .busy(bz16[1])
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    , .ovf(ovf16[1])
`endif
  );

  h_u_dsrca #(.WIDTH(16), .DIGIT(1)) dut16_2 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(ir16[2]),
    .a(a16), .b(b16), .sub(sub16), .out_valid(ov16[2]), .out_ready(out_ready16),
    .out(o16[2]), .busy(bz16[2])
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    , .ovf(ovf16[2])
`endif
  );

  function automatic logic [32:0] model32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [32:0] r;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y};
    end else begin
      r = {1'b0, x} - {1'b0, y};
      r[32] = (x < y);
    end
    return r;
  endfunction

  function automatic logic [16:0] model16(input logic [15:0] x, input logic [15:0] y, input logic s);
    logic [16:0] r;
    if (!s) begin
      r = {1'b0, x} + {1'b0, y};
    end else begin
      r = {1'b0, x} - {1'b0, y};
      r[16] = (x < y);
    end
    return r;
  endfunction

`ifdef H_U_DSRCA_SIGNED_OVF_EN
  function automatic logic ovf32(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] r;
    if (!s) begin
      r = x + y;
      return (x[31] == y[31]) && (r[31] != x[31]);
    end
    r = x - y;
    return (x[31] != y[31]) && (r[31] != x[31]);
  endfunction
`endif

  // Present one operand pair to the 32-bit DUT; call just after a negedge.
  task automatic issue32(input logic [31:0] ia, input logic [31:0] ib, input logic isub);
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL issue_in_ready: got %b, want 1", in_ready);
    end
    a        = ia;
    b        = ib;
    sub      = isub;
    in_valid = 1'b1;
    sb.push_back(model32(ia, ib, isub));
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    sbo.push_back(ovf32(ia, ib, isub));
`endif
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    sub      = 1'($urandom_range(0, 1));
  endtask

  // Wait (bounded) for the 32-bit result, compare it with the scoreboard head.
  task automatic collect32(output int lat);
    logic [W:0] e;
    logic       got;
    logic       bad_run;
    lat     = 0;
    got     = 1'b0;
    bad_run = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) got = 1'b1;
      if (busy !== 1'b1 || in_ready !== 1'b0) bad_run = 1'b1;
    end
    n_tests++;
    if (bad_run) begin
      n_fail++;
      $display("FAIL busy_during_op: busy=%b in_ready=%b, want busy=1 in_ready=0 throughout", busy, in_ready);
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL result_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
      if (sb.size() > 0) void'(sb.pop_front());
`ifdef H_U_DSRCA_SIGNED_OVF_EN
      if (sbo.size() > 0) void'(sbo.pop_front());
`endif
    end else begin
      e = sb.pop_front();
      if (out !== e) begin
        n_fail++;
        $display("FAIL result32: got %h, want %h", out, e);
      end
`ifdef H_U_DSRCA_SIGNED_OVF_EN
      begin
        logic eo;
        eo = sbo.pop_front();
        n_tests++;
        if (ovf !== eo) begin
          n_fail++;
          $display("FAIL ovf32: got %b, want %b", ovf, eo);
        end
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    in_valid    = 1'b0;
    sub         = 1'b0;
    a           = '0;
    b           = '0;
    out_ready   = 1'b1;
    in_valid16  = 1'b0;
    sub16       = 1'b0;
    a16         = '0;
    b16         = '0;
    out_ready16 = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, want 0 0 0", in_ready, out_valid, busy);
    end
    n_tests++;
    if (out !== 33'd0) begin
      n_fail++;
      $display("FAIL reset_out: got %h, want 0", out);
    end
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    n_tests++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b, want 0", ovf);
    end
`endif
    rst = 1'b0;
    @(negedge clk);
    n_tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: in_ready=%b busy=%b, want 1 0", in_ready, busy);
    end
  endtask

  task automatic test_add_carry();
    int lat;
    issue32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    collect32(lat);
    n_tests++;
    if (lat != int'(ND) + 1) begin
      n_fail++;
      $display("FAIL add_latency: got %0d, want %0d", lat, ND + 1);
    end
    n_tests++;
    if (out !== 33'h1_0000_0000) begin
      n_fail++;
      $display("FAIL add_carry: got %h, want 100000000", out);
    end
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL add_handoff: out_valid=%b busy=%b in_ready=%b, want 0 0 1", out_valid, busy, in_ready);
    end
  endtask

  task automatic test_sub();
    int lat;
    issue32(32'd5, 32'd7, 1'b1);
    collect32(lat);
    n_tests++;
    if (out !== 33'h1_FFFF_FFFE) begin
      n_fail++;
      $display("FAIL sub_5_7: got %h, want 1fffffffe", out);
    end
    @(negedge clk);
    issue32(32'd7, 32'd5, 1'b1);
    collect32(lat);
    n_tests++;
    if (out !== 33'h0_0000_0002) begin
      n_fail++;
      $display("FAIL sub_7_5: got %h, want 000000002", out);
    end
    @(negedge clk);
  endtask

  task automatic test_stall();
    int lat;
    out_ready = 1'b0;
    issue32(32'd100, 32'd23, 1'b0);
    collect32(lat);
    for (int i = 0; i < 10; i++) begin
      a        = $urandom;
      b        = $urandom;
      sub      = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge clk);
      n_tests++;
      if (out !== 33'd123 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL stall_hold: out=%h out_valid=%b in_ready=%b busy=%b, want 07b 1 0 1",
                 out, out_valid, in_ready, busy);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || out !== 33'd123) begin
      n_fail++;
      $display("FAIL stall_release: out=%h out_valid=%b busy=%b in_ready=%b, want 07b 0 0 1",
               out, out_valid, busy, in_ready);
    end
    issue32(32'hDEAD_BEEF, 32'h0101_0101, 1'b0);
    collect32(lat);
    n_tests++;
    if (out !== 33'h0_DFAE_BFF0) begin
      n_fail++;
      $display("FAIL stall_next_op: got %h, want 0dfaebff0", out);
    end
    @(negedge clk);
  endtask

  task automatic test_rst_mid_run();
    int   lat;
    logic bad;
    issue32(32'hAAAA_0000, 32'h5555_FFFF, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || out !== 33'd0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: out=%h out_valid=%b busy=%b in_ready=%b, want 0 0 0 0",
               out, out_valid, busy, in_ready);
    end
    void'(sb.pop_back());
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    void'(sbo.pop_back());
`endif
    @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    repeat (ND + 2) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
    end
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL rst_no_result: out_valid=%b in_ready=%b, want 0 1 after abort", out_valid, in_ready);
    end
    issue32(32'h1234_5678, 32'h1111_1111, 1'b0);
    collect32(lat);
    n_tests++;
    if (out !== 33'h0_2345_6789) begin
      n_fail++;
      $display("FAIL rst_next_op: got %h, want 023456789", out);
    end
    @(negedge clk);
  endtask

`ifdef H_U_DSRCA_SIGNED_OVF_EN
  task automatic test_ovf();
    int lat;
    issue32(32'h7FFF_FFFF, 32'd1, 1'b0);
    collect32(lat);
    n_tests++;
    if (ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_add_max: got %b, want 1", ovf);
    end
    @(negedge clk);
    issue32(32'h8000_0000, 32'd1, 1'b1);
    collect32(lat);
    n_tests++;
    if (ovf !== 1'b1 || out !== 33'h0_7FFF_FFFF) begin
      n_fail++;
      $display("FAIL ovf_sub_min: ovf=%b out=%h, want 1 07fffffff", ovf, out);
    end
    @(negedge clk);
    issue32(32'd3, 32'd4, 1'b0);
    collect32(lat);
    n_tests++;
    if (ovf !== 1'b0 || out !== 33'd7) begin
      n_fail++;
      $display("FAIL ovf_small: ovf=%b out=%h, want 0 000000007", ovf, out);
    end
    @(negedge clk);
  endtask
`endif

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_back_to_back();
    int  lat;
    time t_acc;
    time t_prev;
    t_prev = 0;
    for (int n = 0; n < 40; n++) begin
      issue32(pick32(), pick32(), 1'($urandom_range(0, 1)));
      t_acc = $time;
      if (n > 0) begin
        n_tests++;
        if (t_acc - t_prev != time'((ND + 2) * 10)) begin
          n_fail++;
          $display("FAIL issue_interval: got %0t, want %0d", t_acc - t_prev, (ND + 2) * 10);
        end
      end
      t_prev = t_acc;
      collect32(lat);
      n_tests++;
      if (lat != int'(ND) + 1) begin
        n_fail++;
        $display("FAIL b2b_latency: got %0d, want %0d", lat, ND + 1);
      end
      // Request during the handoff cycle must not be taken
      in_valid = 1'b1;
      a        = $urandom;
      b        = $urandom;
      n_tests++;
      if (in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL handoff_ready: got %b, want 0", in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random16();
    int          lat_exp [3];
    int          cyc;
    logic        seen [3];
    logic [16:0] e;
    logic [15:0] x;
    logic [15:0] y;
    logic        s;
    lat_exp = '{2, 5, 17};
    for (int n = 0; n < 1000; n++) begin
      x = 16'($urandom);
      y = 16'($urandom);
      s = 1'($urandom_range(0, 1));
      if (n % 16 == 0) x = 16'hFFFF;
      if (n % 16 == 1) y = 16'hFFFF;
      if (n % 16 == 2) y = x;
      n_tests++;
      if (ir16[0] !== 1'b1 || ir16[1] !== 1'b1 || ir16[2] !== 1'b1) begin
        n_fail++;
        $display("FAIL r16_ready: got %b%b%b, want 111", ir16[0], ir16[1], ir16[2]);
      end
      a16        = x;
      b16        = y;
      sub16      = s;
      in_valid16 = 1'b1;
      e = model16(x, y, s);
      sb16_0.push_back(e);
      sb16_1.push_back(e);
      sb16_2.push_back(e);
      @(posedge clk);
      #1;
      in_valid16 = 1'b0;
      a16        = 16'($urandom);
      b16        = 16'($urandom);
      sub16      = 1'($urandom_range(0, 1));
      seen       = '{1'b0, 1'b0, 1'b0};
      cyc        = 0;
      while (!(seen[0] && seen[1] && seen[2]) && cyc < 25) begin
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 3; k++) begin
          if (!seen[k] && ov16[k] === 1'b1) begin
            seen[k] = 1'b1;
            case (k)
              0:       e = sb16_0.pop_front();
              1:       e = sb16_1.pop_front();
              default: e = sb16_2.pop_front();
            endcase
            n_tests++;
            if (o16[k] !== e) begin
              n_fail++;
              $display("FAIL r16_result[%0d] op %0d: got %h, want %h", k, n, o16[k], e);
            end
            n_tests++;
            if (cyc != lat_exp[k]) begin
              n_fail++;
              $display("FAIL r16_latency[%0d]: got %0d, want %0d", k, cyc, lat_exp[k]);
            end
          end
        end
      end
      for (int k = 0; k < 3; k++) begin
        if (!seen[k]) begin
          n_tests++;
          n_fail++;
          $display("FAIL r16_timeout[%0d]: out_valid=%b, want 1 within 25 cycles", k, ov16[k]);
          case (k)
            0:       void'(sb16_0.pop_front());
            1:       void'(sb16_1.pop_front());
            default: void'(sb16_2.pop_front());
          endcase
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add_carry();
    test_sub();
    test_stall();
    test_rst_mid_run();
`ifdef H_U_DSRCA_SIGNED_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_random16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
